// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core definitions for the register-file write-back path.
//   XLEN        : datapath width
//   REG_ADDR_W  : architectural register index width
//   wb_entry_t  : one held long-latency result, layout {rd, data}
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef struct packed {
        reg_addr_t rd;
        xlen_t     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Holding buffer for long-latency results waiting for the regfile write port.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   push_i, data_i : enqueue an entry at the clock edge
//   pop_i          : dequeue the head at the clock edge
//   head_o         : oldest entry (valid when !empty_o)
//   full_o, empty_o: registered occupancy flags
// DEPTH must be a power of 2 (>= 2) so the pointers wrap by overflow.
module wb_result_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  wb_entry_t data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [PW:0]       cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    // A push while full is accepted only if the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through cnt_q.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the pipeline WB stage and
// buffered long-latency unit results, with a starvation guard and an optional
// pending-register scoreboard (macro REGFILE_WB_SCOREBOARD_EN).
// Ports:
//   clk_i, rst_i                   : clock, asynchronous active-low reset
//   pipe_wr_en_i/rd_i/data_i       : pipeline WB write request
//   lu_valid_i/rd_i/data_i         : long-latency result; lu_ready_o accepts
//   issue_valid_i/issue_rd_i       : ID issues a long-latency op to rd
//   rs1_label_i/rs2_label_i        : ID source registers for the hazard check
//   hazard_o                       : ID must stall
//   stall_o                        : forced-drain cycle, pipeline holds WB
//   rf_wr_en_o/rf_rd_o/rf_data_o   : regfile write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      pipe_wr_en_i,
    input  reg_addr_t pipe_rd_i,
    input  xlen_t     pipe_data_i,
    input  logic      lu_valid_i,
    input  reg_addr_t lu_rd_i,
    input  xlen_t     lu_data_i,
    output logic      lu_ready_o,
    input  logic      issue_valid_i,
    input  reg_addr_t issue_rd_i,
    input  reg_addr_t rs1_label_i,
    input  reg_addr_t rs2_label_i,
    output logic      hazard_o,
    output logic      stall_o,
    output logic      rf_wr_en_o,
    output reg_addr_t rf_rd_o,
    output xlen_t     rf_data_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t     head;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic          pipe_grant, deny;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    // Ready depends only on the registered fill level; rst_i only forces it
    // low while the block is held in reset.
    assign lu_ready_o = rst_i && !fifo_full;

    // x0 results never enter the buffer, so the head always has rd != 0.
    assign fifo_push = lu_valid_i && lu_ready_o && (lu_rd_i != '0);

    assign pipe_grant = pipe_wr_en_i && (pipe_rd_i != '0) && !stall_q;
    assign fifo_pop   = !pipe_grant && !fifo_empty;
    assign deny       = pipe_grant && !fifo_empty;

    assign rf_wr_en_o = pipe_grant || fifo_pop;
    assign rf_rd_o    = pipe_grant ? pipe_rd_i   : head.rd;
    assign rf_data_o  = pipe_grant ? pipe_data_i : head.data;
    assign stall_o    = stall_q;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (fifo_push),
        .data_i ('{rd: lu_rd_i, data: lu_data_i}),
        .pop_i  (fifo_pop),
        .head_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Starve counter: the edge that would bring the count to the limit instead
    // clears it and raises stall_o for the following cycle. A deny cannot pop,
    // so the buffer is still non-empty when the stall cycle grants its head.
    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (deny) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pend_q, pend_d, set_m, clr_m;

    // Set wins over clear so a re-issue to a draining rd stays pending.
    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (issue_valid_i) set_m[issue_rd_i] = 1'b1;
        if (fifo_pop)      clr_m[head.rd]    = 1'b1;
        pend_d    = (pend_q & ~clr_m) | set_m;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign hazard_o = pend_q[rs1_label_i] || pend_q[rs2_label_i] ||
                      (issue_valid_i && pend_q[issue_rd_i]);
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid_i, issue_rd_i, rs1_label_i, rs2_label_i};
    assign hazard_o  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic      clk_i = 1'b0;
    logic      rst_i = 1'b0;
    logic      pipe_wr_en_i = 1'b0;
    reg_addr_t pipe_rd_i = '0;
    xlen_t     pipe_data_i = '0;
    logic      lu_valid_i = 1'b0;
    reg_addr_t lu_rd_i = '0;
    xlen_t     lu_data_i = '0;
    logic      lu_ready_o;
    logic      issue_valid_i = 1'b0;
    reg_addr_t issue_rd_i = '0;
    reg_addr_t rs1_label_i = '0;
    reg_addr_t rs2_label_i = '0;
    logic      hazard_o, stall_o, rf_wr_en_o;
    reg_addr_t rf_rd_o;
    xlen_t     rf_data_o;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_wr_en_i(pipe_wr_en_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
        .lu_ready_o(lu_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .rs1_label_i(rs1_label_i), .rs2_label_i(rs2_label_i),
        .hazard_o(hazard_o), .stall_o(stall_o),
        .rf_wr_en_o(rf_wr_en_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o)
    );

    typedef struct { bit wr; bit ready; bit stall; bit hazard; } ctl_t;
    typedef struct { bit [4:0] rd; bit [31:0] data; } wr_t;

    ctl_t ctl_q[$];   // per-cycle expected flags
    wr_t  wr_q[$];    // expected regfile writes, in order

    // Reference model: buffer as a queue, starvation as a plain count.
    wr_t      m_fifo[$];
    int       m_starve = 0;
    bit       m_stall  = 0;
    bit [31:0] m_pend  = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one flag check per cycle, write payload popped when DUT writes.
    always @(negedge clk_i) begin
        ctl_t e;
        wr_t  w;
        if (ctl_q.size() != 0) begin
            e = ctl_q.pop_front();
            chk1("lu_ready_o", lu_ready_o, e.ready);
            chk1("stall_o", stall_o, e.stall);
            chk1("hazard_o", hazard_o, e.hazard);
            chk1("rf_wr_en_o", rf_wr_en_o, e.wr);
            if (rf_wr_en_o) begin
                chk1("rd_nonzero", rf_rd_o == '0, 1'b0);
                if (wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: rd %0d data %h", rf_rd_o, rf_data_o);
                end else begin
                    w = wr_q.pop_front();
                    chk32("rf_rd_o", 32'(rf_rd_o), 32'(w.rd));
                    chk32("rf_data_o", rf_data_o, w.data);
                end
            end else if (e.wr && wr_q.size() != 0) begin
                w = wr_q.pop_front();
            end
        end
    end

    task automatic step(input bit pwe, input bit [4:0] prd, input bit [31:0] pd,
                        input bit lv, input bit [4:0] lrd, input bit [31:0] ld,
                        input bit iv, input bit [4:0] ird,
                        input bit [4:0] r1, input bit [4:0] r2);
        ctl_t e;
        wr_t  w;
        bit   pg, pop, push, nonempty;
        bit [4:0] pop_rd;
        pipe_wr_en_i = pwe; pipe_rd_i = prd; pipe_data_i = pd;
        lu_valid_i = lv; lu_rd_i = lrd; lu_data_i = ld;
        issue_valid_i = iv; issue_rd_i = ird;
        rs1_label_i = r1; rs2_label_i = r2;

        nonempty = m_fifo.size() > 0;
        pg   = pwe && prd != 0 && !m_stall;
        pop  = !pg && nonempty;
        e.ready = m_fifo.size() < DEPTH;
        push = lv && e.ready && lrd != 0;
        e.stall = m_stall;
        e.wr = pg || pop;
`ifdef REGFILE_WB_SCOREBOARD_EN
        e.hazard = m_pend[r1] || m_pend[r2] || (iv && m_pend[ird]);
`else
        e.hazard = 1'b0;
`endif
        pop_rd = nonempty ? m_fifo[0].rd : 5'd0;
        if (pg)       begin w.rd = prd; w.data = pd; wr_q.push_back(w); end
        else if (pop) wr_q.push_back(m_fifo[0]);
        ctl_q.push_back(e);

        @(posedge clk_i); #1;

        if (pop) w = m_fifo.pop_front();
        if (push) begin w.rd = lrd; w.data = ld; m_fifo.push_back(w); end
`ifdef REGFILE_WB_SCOREBOARD_EN
        if (pop) m_pend[pop_rd] = 1'b0;
        if (iv && ird != 0) m_pend[ird] = 1'b1;
`else
        pop_rd = 5'd0;
`endif
        m_stall = 1'b0;
        if (pop) m_starve = 0;
        else if (pg && nonempty) begin
            m_starve++;
            if (m_starve == LIMIT) begin
                m_starve = 0;
                m_stall  = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        ctl_t e;
        pipe_wr_en_i = 0; lu_valid_i = 0; issue_valid_i = 0;
        rst_i = 1'b0;
        m_fifo.delete(); m_starve = 0; m_stall = 0; m_pend = '0;
        e.wr = 0; e.ready = 0; e.stall = 0; e.hazard = 0;
        for (int i = 0; i < n; i++) begin
            ctl_q.push_back(e);
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;
    endtask

    bit        r_pwe;
    bit [4:0]  r_prd;
    bit [31:0] r_pd;

    initial begin
        @(posedge clk_i); #1;
        do_reset(3);

        // Idle port: result accepted now, written exactly one cycle later.
        step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(3);

        // Busy pipeline: two results wait, forced drains via stall_o.
        step(1, 1, 32'h100, 1, 3, 32'h3333, 0, 0, 0, 0);
        step(1, 2, 32'h101, 1, 4, 32'h4444, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++)
            step(1, 5'(1 + i % 31), 32'h200 + i, 1, 9, 32'h9999, 0, 0, 0, 0);
        idle(3);

        // Back-to-back results with a bursty pipeline: order across wrap.
        for (int i = 0; i < 10; i++)
            step(i % 3 != 2, 5'(20 + i), 32'hA000 + i, 1, 5'(1 + i), 32'hC000 + i, 0, 0, 0, 0);
        idle(4);

        // Scoreboard: issue rd=7, source 7 waits until the pop, WAW re-issue.
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 2, 32'h1, 0, 0, 0, 1, 7, 7, 0);
        step(1, 2, 32'h2, 1, 7, 32'h7777, 0, 0, 7, 0);
        step(1, 2, 32'h3, 0, 0, 0, 0, 0, 7, 7);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

        // x0 from both sources never writes.
        step(1, 0, 32'hFFFF, 1, 0, 32'hEEEE, 0, 0, 0, 0);
        step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Reset mid-drain with two held entries and pending bits.
        step(1, 1, 32'h11, 1, 9, 32'h9, 1, 9, 0, 0);
        step(1, 1, 32'h12, 1, 10, 32'hA, 1, 10, 9, 10);
        step(1, 1, 32'h13, 0, 0, 0, 0, 0, 9, 10);
        do_reset(1);
        step(1, 6, 32'h66, 0, 0, 0, 0, 0, 9, 10);
        idle(2);

        // Randomized traffic; a stalled pipeline write is re-presented.
        r_pwe = 0; r_prd = 0; r_pd = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1);
            if (!m_stall) begin
                r_pwe = $urandom_range(0, 3) != 0;
                r_prd = 5'($urandom_range(0, 31));
                r_pd  = $urandom;
            end
            step(r_pwe, r_prd, r_pd,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(12);

        @(negedge clk_i); #1;
        chk32("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
